// File: rtl/recognizer_sequencer_pkg.sv
// Shared types and constants for the digit-recognizer control path.
package recognizer_pkg;

    localparam int         NUM_BYTES  = 72;
    localparam logic [7:0] START_BYTE = 8'h00;
    localparam logic [7:0] END_BYTE   = 8'hFF;
    localparam logic [7:0] ERR_CODE   = 8'hEE;

    // Byte counter must hold NUM_BYTES itself (no wrap after the last byte).
    localparam int ADDR_W = $clog2(NUM_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WAIT_END,
        INFER,
        RESULT
    } seq_state_t;

    // Two 4-bit pixels per byte; element [0] (low nibble) is the even pixel.
    typedef logic [1:0][3:0] pixel_byte_t;

    function automatic logic [7:0] digit_to_tx(input logic [3:0] digit);
        return {4'h0, digit};
    endfunction

endpackage

// File: rtl/recognizer_sequencer_if.sv
// Handshake bundle between the sequencer and its SPI, pixel-buffer and
// inference neighbours.
interface recognizer_sequencer_if;
    import recognizer_pkg::*;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              pix_we;
    logic [ADDR_W-1:0] pix_waddr;
    logic [7:0]        pix_wdata;
    logic              start_infer;
    logic              infer_done;
    logic [3:0]        infer_digit;
    logic [7:0]        tx_data;
    logic              tx_load;
    logic              tx_read;
    logic              busy;
    logic              frame_error;

    // Sequencer side.
    modport master (
        input  rx_data, rx_valid, infer_done, infer_digit, tx_read,
        output pix_we, pix_waddr, pix_wdata, start_infer,
               tx_data, tx_load, busy, frame_error
    );

    // Environment side (receiver, inference engine, transmitter).
    modport slave (
        output rx_data, rx_valid, infer_done, infer_digit, tx_read,
        input  pix_we, pix_waddr, pix_wdata, start_infer,
               tx_data, tx_load, busy, frame_error
    );

endinterface

// File: rtl/recognizer_sequencer_timeout.sv
// Clear/enable up-counter that saturates at LIMIT and flags terminal count.
module seq_timeout_counter #(
    parameter int LIMIT = 8000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;
    logic          w_tc;

    assign w_tc = (r_count == CW'(LIMIT));
    assign o_tc = w_tc;

    // Count enabled cycles; hold at LIMIT so the flag stays asserted.
    always_ff @(posedge clk) begin
        if (!n_rst)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en && !w_tc)
            r_count <= r_count + CW'(1);
    end

endmodule

// File: rtl/recognizer_sequencer.sv
// Frame sequencer: collects pixel bytes, triggers inference, reports result.
module recognizer_sequencer
    import recognizer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic                   clk,
    input  logic                   n_rst,
    recognizer_sequencer_if.master bus
);

    seq_state_t        r_state;
    seq_state_t        w_next_state;

    logic [ADDR_W-1:0] r_byte_cnt;
    logic              r_pix_we;
    logic [ADDR_W-1:0] r_pix_waddr;
    pixel_byte_t       r_pix_wdata;
    logic              r_start_infer;
    logic              r_tx_load;
    logic [7:0]        r_tx_data;
    logic              r_frame_error;

    logic w_rx_start;
    logic w_rx_end;
    logic w_last_byte;
    logic w_timeout;
    logic w_busy;
    logic w_frame_start;
    logic w_write;
    logic w_fire;
    logic w_err;
    logic w_done;
    logic w_tmo_en;

    assign w_rx_start  = bus.rx_valid && (bus.rx_data == START_BYTE);
    assign w_rx_end    = bus.rx_valid && (bus.rx_data == END_BYTE);
    assign w_last_byte = (r_byte_cnt == ADDR_W'(NUM_BYTES - 1));

    seq_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .n_rst (n_rst),
        .i_clr (w_fire),
        .i_en  (w_tmo_en),
        .o_tc  (w_timeout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state decode; a new START in RESULT takes priority over tx_read.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_rx_start) w_next_state = RECV;
            RECV:     if (bus.rx_valid && w_last_byte) w_next_state = WAIT_END;
            WAIT_END: if (bus.rx_valid) w_next_state = w_rx_end ? INFER : RESULT;
            INFER:    if (bus.infer_done || w_timeout) w_next_state = RESULT;
            RESULT: begin
                if (w_rx_start)       w_next_state = RECV;
                else if (bus.tx_read) w_next_state = IDLE;
            end
            default:  w_next_state = IDLE;
        endcase
    end

    // Per-state action decode; infer_done outranks a coincident timeout.
    always_comb begin
        w_busy        = (r_state != IDLE);
        w_frame_start = 1'b0;
        w_write       = 1'b0;
        w_fire        = 1'b0;
        w_err         = 1'b0;
        w_done        = 1'b0;
        w_tmo_en      = 1'b0;
        case (r_state)
            IDLE:     w_frame_start = w_rx_start;
            RECV:     w_write = bus.rx_valid;
            WAIT_END: begin
                w_fire = w_rx_end;
                w_err  = bus.rx_valid && !w_rx_end;
            end
            INFER: begin
                w_tmo_en = 1'b1;
                w_done   = bus.infer_done;
                w_err    = !bus.infer_done && w_timeout;
            end
            RESULT:   w_frame_start = w_rx_start;
            default:  ;
        endcase
    end

    // Registered strobes, pixel write path, result byte and error flag.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_byte_cnt    <= '0;
            r_pix_we      <= 1'b0;
            r_pix_waddr   <= '0;
            r_pix_wdata   <= '0;
            r_start_infer <= 1'b0;
            r_tx_load     <= 1'b0;
            r_tx_data     <= 8'h00;
            r_frame_error <= 1'b0;
        end else begin
            r_pix_we      <= w_write;
            r_start_infer <= w_fire;
            r_tx_load     <= w_err || w_done;
            if (w_frame_start) begin
                r_byte_cnt    <= '0;
                r_frame_error <= 1'b0;
            end
            if (w_write) begin
                r_pix_waddr <= r_byte_cnt;
                r_pix_wdata <= pixel_byte_t'(bus.rx_data);
                r_byte_cnt  <= r_byte_cnt + ADDR_W'(1);
            end
            if (w_err) begin
                r_frame_error <= 1'b1;
                r_tx_data     <= ERR_CODE;
            end else if (w_done) begin
                r_tx_data <= digit_to_tx(bus.infer_digit);
            end
        end
    end

    assign bus.pix_we      = r_pix_we;
    assign bus.pix_waddr   = r_pix_waddr;
    assign bus.pix_wdata   = r_pix_wdata;
    assign bus.start_infer = r_start_infer;
    assign bus.tx_load     = r_tx_load;
    assign bus.tx_data     = r_tx_data;
    assign bus.busy        = w_busy;
    assign bus.frame_error = r_frame_error;

endmodule

// File: tb/tb_recognizer_sequencer.sv
// Randomized frame-level bench for recognizer_sequencer.
module tb_recognizer_sequencer;

    localparam int NB  = 72;
    localparam int TMO = 8000;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    recognizer_sequencer_if bus ();

    recognizer_sequencer #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- observation ----------------
    logic [15:0] wr_q[$];
    int          n_start = 0;
    int          n_load  = 0;
    int          n_wide  = 0;
    int          cyc     = 0;
    int          t_start = 0;
    int          t_load  = 0;
    logic        p_we = 1'b0, p_st = 1'b0, p_ld = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.pix_we) wr_q.push_back(16'({bus.pix_waddr, bus.pix_wdata}));
        if (bus.start_infer) begin n_start++; t_start = cyc; end
        if (bus.tx_load)     begin n_load++;  t_load  = cyc; end
        if ((p_we && bus.pix_we) || (p_st && bus.start_infer) || (p_ld && bus.tx_load))
            n_wide++;
        p_we = bus.pix_we;
        p_st = bus.start_infer;
        p_ld = bus.tx_load;
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] frame[NB];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        repeat ($urandom_range(1, 3)) tick();
    endtask

    task automatic send_payload(input logic [7:0] term);
        for (int i = 0; i < NB; i++) send_byte(frame[i]);
        send_byte(term);
    endtask

    task automatic pulse_done(input logic [3:0] d);
        bus.infer_digit = d;
        bus.infer_done  = 1'b1;
        tick();
        bus.infer_done  = 1'b0;
        bus.infer_digit = 4'($urandom);
    endtask

    task automatic pulse_read();
        bus.tx_read = 1'b1;
        tick();
        bus.tx_read = 1'b0;
        tick();
    endtask

    // Pixel k of the nominal pattern has value k mod 16, even pixel in the low nibble.
    task automatic make_pattern_frame();
        for (int i = 0; i < NB; i++) begin
            int lo, hi;
            lo = (2 * i) % 16;
            hi = (2 * i + 1) % 16;
            frame[i] = 8'(hi * 16 + lo);
        end
    endtask

    task automatic make_random_frame();
        for (int i = 0; i < NB; i++) frame[i] = 8'($urandom);
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, "_wr_count"}, wr_q.size(), NB);
        n = (wr_q.size() < NB) ? wr_q.size() : NB;
        for (int i = 0; i < n; i++)
            check($sformatf("%s_wr%0d", tag, i), wr_q[i], {1'b0, 7'(i), frame[i]});
        wr_q.delete();
    endtask

    task automatic wait_load(input string tag, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (bus.tx_load) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_tx_load_seen"}, 32'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    // Full frame with a good terminator and an inference answer after `delay` cycles.
    task automatic run_good(input string tag, input logic [3:0] digit, input int delay);
        n_start = 0;
        n_load  = 0;
        send_byte(8'h00);
        check({tag, "_busy_recv"}, 32'(bus.busy), 1);
        send_payload(8'hFF);
        check({tag, "_start_once"}, n_start, 1);
        repeat (delay / 2) tick();
        send_byte(8'($urandom));              // ignored while inferring
        repeat (delay / 2) tick();
        check({tag, "_no_early_load"}, n_load, 0);
        pulse_done(digit);
        wait_load(tag, 4);
        check({tag, "_tx_data"}, bus.tx_data, {28'h0, digit});
        check({tag, "_load_once"}, n_load, 1);
        check({tag, "_start_still_once"}, n_start, 1);
        check({tag, "_ferr"}, 32'(bus.frame_error), 0);
        check({tag, "_busy_result"}, 32'(bus.busy), 1);
        check_writes(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.rx_data     = 8'h00;
        bus.rx_valid    = 1'b0;
        bus.infer_done  = 1'b0;
        bus.infer_digit = 4'h0;
        bus.tx_read     = 1'b0;
        repeat (3) tick();

        check("rst_busy",   32'(bus.busy),        0);
        check("rst_ferr",   32'(bus.frame_error), 0);
        check("rst_tx",     32'(bus.tx_data),     0);
        check("rst_waddr",  32'(bus.pix_waddr),   0);
        check("rst_wdata",  32'(bus.pix_wdata),   0);
        check("rst_strobe", 32'({bus.pix_we, bus.start_infer, bus.tx_load}), 0);
        n_rst = 1'b1;
        tick();

        // Non-start bytes in IDLE are dropped.
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(1, 255)));
        check("idle_junk_busy", 32'(bus.busy), 0);
        check("idle_junk_wr",   wr_q.size(),   0);

        // Nominal pattern frame, digit 7 after ~100 cycles.
        make_pattern_frame();
        run_good("nom", 4'd7, 100);

        // Host clocks 0xFF while reading back: ignored.
        for (int i = 0; i < 3; i++) send_byte(8'hFF);
        check("res_ff_busy", 32'(bus.busy),    1);
        check("res_ff_tx",   32'(bus.tx_data), 8'h07);
        check("res_ff_load", n_load,           1);
        check("res_ff_wr",   wr_q.size(),      0);
        pulse_read();
        check("read_idle_busy", 32'(bus.busy),    0);
        check("read_idle_tx",   32'(bus.tx_data), 8'h07);

        // Bad terminator.
        make_random_frame();
        n_start = 0;
        n_load  = 0;
        send_byte(8'h00);
        send_payload(8'h12);
        check("bad_no_start", n_start,              0);
        check("bad_load",     n_load,               1);
        check("bad_tx",       32'(bus.tx_data),     8'hEE);
        check("bad_ferr",     32'(bus.frame_error), 1);
        check("bad_busy",     32'(bus.busy),        1);
        check_writes("bad");

        // New START in RESULT abandons the error result; tx_data held until next load.
        send_byte(8'h00);
        check("restart_ferr", 32'(bus.frame_error), 0);
        check("restart_busy", 32'(bus.busy),        1);
        check("restart_tx",   32'(bus.tx_data),     8'hEE);
        frame[5]  = 8'h00;
        frame[40] = 8'hFF;
        n_start = 0;
        n_load  = 0;
        send_payload(8'hFF);
        check("mark_start", n_start, 1);
        check("mark_tx_held", 32'(bus.tx_data), 8'hEE);
        pulse_done(4'd3);
        wait_load("mark", 4);
        check("mark_tx", 32'(bus.tx_data), 8'h03);
        check_writes("mark");
        pulse_read();

        // Marker values inside pixel data of a fresh frame.
        make_random_frame();
        frame[5]  = 8'h00;
        frame[40] = 8'hFF;
        frame[0]  = 8'hFF;
        run_good("mark2", 4'($urandom), 20);
        pulse_read();

        // Inference timeout.
        make_random_frame();
        n_start = 0;
        n_load  = 0;
        send_byte(8'h00);
        send_payload(8'hFF);
        check("tmo_start", n_start, 1);
        wait_load("tmo", TMO + 100);
        check("tmo_latency_ok", 32'((t_load - t_start) >= TMO && (t_load - t_start) <= TMO + 2), 1);
        check("tmo_tx",   32'(bus.tx_data),     8'hEE);
        check("tmo_ferr", 32'(bus.frame_error), 1);
        check("tmo_busy", 32'(bus.busy),        1);
        check_writes("tmo");
        pulse_done(4'd5);                       // late answer
        repeat (3) tick();
        check("late_done_tx",   32'(bus.tx_data), 8'hEE);
        check("late_done_load", n_load,           1);
        pulse_read();
        pulse_done(4'd6);                       // stray answer in IDLE
        repeat (3) tick();
        check("idle_done_busy", 32'(bus.busy), 0);
        check("idle_done_load", n_load,        1);

        // Answer just inside the timeout window still wins.
        make_random_frame();
        n_start = 0;
        n_load  = 0;
        send_byte(8'h00);
        send_payload(8'hFF);
        for (int k = 0; k < TMO + 10 && (cyc - t_start) < TMO - 5; k++) tick();
        pulse_done(4'd9);
        wait_load("near", 4);
        check("near_tx",   32'(bus.tx_data),     8'h09);
        check("near_ferr", 32'(bus.frame_error), 0);
        check_writes("near");
        pulse_read();

        // Reset mid-frame.
        make_random_frame();
        send_byte(8'h00);
        for (int i = 0; i < 30; i++) send_byte(frame[i]);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check("rst_mid_busy", 32'(bus.busy),   0);
        check("rst_mid_we",   32'(bus.pix_we), 0);
        check("rst_mid_wr30", wr_q.size(),     30);
        wr_q.delete();
        make_random_frame();
        run_good("after_rst", 4'($urandom), 30);
        pulse_read();

        // Reset mid-inference; a later infer_done is ignored.
        make_random_frame();
        n_load = 0;
        send_byte(8'h00);
        send_payload(8'hFF);
        repeat (20) tick();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        repeat (3) tick();
        pulse_done(4'd4);
        repeat (4) tick();
        check("rst_inf_busy", 32'(bus.busy),    0);
        check("rst_inf_load", n_load,           0);
        check("rst_inf_tx",   32'(bus.tx_data), 0);
        wr_q.delete();

        // Random frames; readback randomly skipped by the next START.
        for (int it = 0; it < 4; it++) begin
            make_random_frame();
            run_good($sformatf("rnd%0d", it), 4'($urandom), int'($urandom_range(4, 150)));
            if ($urandom_range(0, 1) == 1) begin
                pulse_read();
                check($sformatf("rnd%0d_idle", it), 32'(bus.busy), 0);
            end
        end

        // tx_read and START in the same cycle -> new frame.
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b1;
        bus.tx_read  = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.tx_read  = 1'b0;
        tick();
        check("both_busy", 32'(bus.busy), 1);
        make_random_frame();
        n_start = 0;
        send_payload(8'hFF);
        check("both_start", n_start, 1);
        pulse_done(4'd2);
        wait_load("both", 4);
        check("both_tx", 32'(bus.tx_data), 8'h02);
        check_writes("both");
        pulse_read();

        check("strobe_width", n_wide, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
